// File: rtl/mont_arbiter_pkg.sv
// mont_arb_pkg: shared types and helpers for the montgomery-core arbiter.
//   arb_state_e  : sequencer states IDLE..DONE (3-bit encoding)
//   MONT_WIDTH   : default operand/result width of the shared core
//   idx_w()      : index width for an N-entry requester vector (min 1 bit)
package mont_arb_pkg;
  localparam int MONT_WIDTH = 512;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mont_arbiter_if.sv
// mont_arbiter_if: requester-side and core-side signals of the arbiter.
//   master : requesters + multiplier core (drive req/operands, core result/done)
//   slave  : the arbiter (drives gnt/done/err/result/busy and the core controls)
// Operand buses are packed [N_REQ][WIDTH]; slice i belongs to requester i.
interface mont_arbiter_if import mont_arb_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int WIDTH = MONT_WIDTH
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic [N_REQ-1:0][WIDTH-1:0] req_m;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            done;
  logic [N_REQ-1:0]            err;
  logic [WIDTH-1:0]            result;
  logic                        busy;
  logic                        mont_resetn;
  logic                        mont_start;
  logic [WIDTH-1:0]            mont_a;
  logic [WIDTH-1:0]            mont_b;
  logic [WIDTH-1:0]            mont_m;
  logic [WIDTH-1:0]            mont_result;
  logic                        mont_done;

  modport master (
    output req, req_a, req_b, req_m, mont_result, mont_done,
    input  gnt, done, err, result, busy, mont_resetn, mont_start, mont_a, mont_b, mont_m
  );

  modport slave (
    input  req, req_a, req_b, req_m, mont_result, mont_done,
    output gnt, done, err, result, busy, mont_resetn, mont_start, mont_a, mont_b, mont_m
  );
endinterface

// File: rtl/mont_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    : request vector
//   ptr    : highest-priority index this round
//   onehot : winner, first set bit at/after ptr (wrapping)
//   idx    : winner index
//   valid  : any request present
module rr_pick import mont_arb_pkg::*; #(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    logic [IW-1:0] j;
    j      = '0;
    onehot = '0;
    idx    = '0;
    valid  = |req;
    // Scan from the farthest offset back to ptr so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = j;
      end
    end
  end
endmodule

// File: rtl/mont_arbiter.sv
// mont_arbiter: round-robin sharing of one montgomery multiplier core.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : req/req_a/req_b/req_m in, gnt/done/err/result/busy out,
//                 core controls mont_resetn/mont_start/mont_a/b/m out,
//                 mont_result/mont_done in
// Sequence per operation: IDLE(grant) -> LOAD(core reset) -> START -> BUSY -> DONE.
// Optional watchdog: define MONT_ARB_TIMEOUT_EN to abort BUSY after
// TIMEOUT_CYCLES with an err pulse to the owner.
module mont_arbiter import mont_arb_pkg::*; #(
  parameter int N_REQ          = 2,
  parameter int WIDTH          = MONT_WIDTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic           clk,
  input logic           resetn,
  mont_arbiter_if.slave bus
);
  localparam int IW = idx_w(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("N_REQ must be in 2..8");
  end

  arb_state_e       state;
  logic [IW-1:0]    ptr;
  logic [N_REQ-1:0] own_oh;
  logic [N_REQ-1:0] done_q;
  logic [WIDTH-1:0] a_q, b_q, m_q, res_q;
  logic             start_q;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic             tmo;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

`ifdef MONT_ARB_TIMEOUT_EN
  // wd_cnt = cycles elapsed since START (0 during START itself).
  logic [31:0] wd_cnt;
  always_ff @(posedge clk) begin
    if (!resetn || state == ST_LOAD) wd_cnt <= '0;
    else if (state == ST_START || state == ST_BUSY) wd_cnt <= wd_cnt + 32'd1;
  end
  // A core finishing on the limit cycle still counts as a completion.
  assign tmo = (state == ST_BUSY) && (wd_cnt == 32'(TIMEOUT_CYCLES)) && !bus.mont_done;
`else
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be >= 1");
  end
  assign tmo = 1'b0;
`endif

  // Grant is a combinational pulse; gated by resetn so it stays low in reset.
  assign bus.gnt         = (resetn && state == ST_IDLE) ? pick_oh : '0;
  assign bus.err         = tmo ? own_oh : '0;
  assign bus.done        = done_q;
  assign bus.result      = res_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.mont_resetn = resetn && (state != ST_LOAD) && !tmo;
  assign bus.mont_start  = start_q;
  assign bus.mont_a      = a_q;
  assign bus.mont_b      = b_q;
  assign bus.mont_m      = m_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      own_oh  <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
    end else begin
      done_q  <= '0;
      start_q <= 1'b0;
      case (state)
        ST_IDLE: if (pick_vld) begin
          own_oh <= pick_oh;
          a_q    <= bus.req_a[pick_idx];
          b_q    <= bus.req_b[pick_idx];
          m_q    <= bus.req_m[pick_idx];
          ptr    <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
          state  <= ST_LOAD;
        end
        ST_LOAD: begin
          start_q <= 1'b1;
          state   <= ST_START;
        end
        ST_START: state <= ST_BUSY;
        ST_BUSY: begin
          if (bus.mont_done) begin
            res_q  <= bus.mont_result;
            done_q <= own_oh;
            state  <= ST_DONE;
          end else if (tmo) begin
            state <= ST_IDLE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
